// File: rtl/gpu_bg_pkg.sv
// Shared types and constants for the background block cache.
// Line record widths follow the default block geometry below.
package gpu_bg_pkg;

  localparam int PIX_W        = 16;
  localparam int BG_ADR_W     = 15;
  localparam int BG_BLOCK_PIX = 16;
  localparam int BG_LANES     = 2;
  localparam int SLOT_W       = $clog2(BG_BLOCK_PIX / BG_LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    LOAD  = 2'd2,
    FLUSH = 2'd3
  } bgState_t;

  typedef struct packed {
    logic [BG_ADR_W-1:0]     tag;
    logic                    valid;
    logic                    loaded;
    logic [BG_BLOCK_PIX-1:0] mask;
  } bgLine_t;

endpackage

// File: rtl/bg_line_merge.sv
// Per-pixel select between two blocks: i_sel=1 takes i_selData, else i_otherData.
// Used both for load merging (select = written mask) and lane writes (select = lane enables).
module bg_line_merge
  import gpu_bg_pkg::*;
#(
  parameter int NPIX = 16
) (
  input  logic [NPIX-1:0]       i_sel,
  input  logic [PIX_W*NPIX-1:0] i_selData,
  input  logic [PIX_W*NPIX-1:0] i_otherData,
  output logic [PIX_W*NPIX-1:0] o_data
);

  for (genvar gi = 0; gi < NPIX; gi++) begin : gPix
    assign o_data[gi*PIX_W +: PIX_W] = i_sel[gi] ? i_selData[gi*PIX_W +: PIX_W]
                                                 : i_otherData[gi*PIX_W +: PIX_W];
  end

endmodule

// File: rtl/bg_block_cache.sv
// Multi-line write-back cache of background pixel blocks between pixel write-back
// and the DDR block load/save port; zero-latency BG read on hit, flush on request.
module bg_block_cache
  import gpu_bg_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int BLOCK_PIX = BG_BLOCK_PIX,
  parameter int LANES     = BG_LANES,
  parameter int ADR_W     = BG_ADR_W
) (
  input  logic                               clk,
  input  logic                               i_rst,
  input  logic                               i_wrValid,
  input  logic [ADR_W-1:0]                   i_wrAdr,
  input  logic [$clog2(BLOCK_PIX/LANES)-1:0] i_wrSlot,
  input  logic [LANES-1:0]                   i_wrSel,
  input  logic [PIX_W*LANES-1:0]             i_wrData,
  input  logic                               i_needBG,
  output logic                               o_stall,
  output logic [PIX_W*LANES-1:0]             o_bgPix,
  output logic                               o_loadReq,
  output logic [ADR_W-1:0]                   o_loadAdr,
  input  logic                               i_loadAck,
  input  logic [PIX_W*BLOCK_PIX-1:0]         i_loadData,
  output logic                               o_saveReq,
  output logic [ADR_W-1:0]                   o_saveAdr,
  output logic [PIX_W*BLOCK_PIX-1:0]         o_saveData,
  output logic [BLOCK_PIX-1:0]               o_saveMask,
  input  logic                               i_saveAck,
  input  logic                               i_flush,
  output logic                               o_flushDone
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int BLK_W = PIX_W * BLOCK_PIX;
  localparam int GRP_W = PIX_W * LANES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  bgState_t         stateReg, stateNext;
  bgLine_t          lineReg [NUM_LINES];
  logic [BLK_W-1:0] dataReg [NUM_LINES];
  logic [IDX_W-1:0] rrPtrReg;
  logic [IDX_W-1:0] victimReg, victimNext;
  logic             flushingReg, flushingNext;
  logic             flushDoneReg, flushDoneNext;
  logic [ADR_W-1:0] loadAdrReg, loadAdrNext;
  logic [ADR_W-1:0] saveAdrReg;
  logic [BLK_W-1:0] saveDataReg;
  logic [BLOCK_PIX-1:0] saveMaskReg;

  logic             hit, invFound, accept;
  logic [IDX_W-1:0] hitIdx, invIdx, victimSel;
  bgLine_t          hitLine, victimLine;
  logic [BLK_W-1:0] hitData, victimData;
  logic [BLOCK_PIX-1:0] wrEnExp;
  logic [BLK_W-1:0] wrDataRep, wrMerged, ldMerged;

  logic doWrite, doRetag, doCapture, doInval, doMerge, rrAdvance;

  // Tag lookup plus lowest-index invalid line for victim choice.
  always_comb begin
    hit      = 1'b0;
    hitIdx   = '0;
    invFound = 1'b0;
    invIdx   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (lineReg[i].valid && (lineReg[i].tag == i_wrAdr)) begin
        hit    = 1'b1;
        hitIdx = IDX_W'(i);
      end
      if (!lineReg[i].valid) begin
        invFound = 1'b1;
        invIdx   = IDX_W'(i);
      end
    end
  end

  assign victimSel  = invFound ? invIdx : rrPtrReg;
  assign hitLine    = lineReg[hitIdx];
  assign hitData    = dataReg[hitIdx];
  assign victimLine = lineReg[victimReg];
  assign victimData = dataReg[victimReg];

  assign accept  = (stateReg == IDLE) && i_wrValid && hit && (hitLine.loaded || !i_needBG);
  assign o_stall = (stateReg != IDLE) || (i_wrValid && !accept);
  assign o_bgPix = hitData[int'(i_wrSlot) * GRP_W +: GRP_W];

  for (genvar gi = 0; gi < BLOCK_PIX; gi++) begin : gWrEn
    assign wrEnExp[gi] = i_wrSel[gi % LANES] && (int'(i_wrSlot) == (gi / LANES));
    assign wrDataRep[gi*PIX_W +: PIX_W] = i_wrData[(gi % LANES)*PIX_W +: PIX_W];
  end

  bg_line_merge #(.NPIX(BLOCK_PIX)) uWrMerge (
    .i_sel       (wrEnExp),
    .i_selData   (wrDataRep),
    .i_otherData (hitData),
    .o_data      (wrMerged)
  );

  // Written pixels win over freshly loaded DDR data.
  bg_line_merge #(.NPIX(BLOCK_PIX)) uLdMerge (
    .i_sel       (victimLine.mask),
    .i_selData   (victimData),
    .i_otherData (i_loadData),
    .o_data      (ldMerged)
  );

  always_comb begin
    stateNext     = stateReg;
    victimNext    = victimReg;
    loadAdrNext   = loadAdrReg;
    flushingNext  = flushingReg;
    flushDoneNext = 1'b0;
    doWrite       = 1'b0;
    doRetag       = 1'b0;
    doCapture     = 1'b0;
    doInval       = 1'b0;
    doMerge       = 1'b0;
    rrAdvance     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (accept || i_flush) begin
          doWrite = accept;
          if (i_flush) begin
            stateNext    = FLUSH;
            victimNext   = '0;
            flushingNext = 1'b1;
          end
        end else if (i_wrValid && !hit) begin
          victimNext = victimSel;
          rrAdvance  = !invFound;
          if (|lineReg[victimSel].mask) begin
            stateNext = EVICT;
            doCapture = 1'b1;
          end else begin
            doRetag = 1'b1;
            if (i_needBG) begin
              stateNext   = LOAD;
              loadAdrNext = i_wrAdr;
            end
          end
        end else if (i_wrValid) begin
          // Hit on a line without BG data while blending is on.
          stateNext   = LOAD;
          victimNext  = hitIdx;
          loadAdrNext = hitLine.tag;
        end
      end
      EVICT: begin
        if (i_saveAck) begin
          if (flushingReg) begin
            doInval = 1'b1;
            if (victimReg == LAST_IDX) begin
              stateNext     = IDLE;
              flushDoneNext = 1'b1;
              flushingNext  = 1'b0;
            end else begin
              stateNext  = FLUSH;
              victimNext = victimReg + 1'b1;
            end
          end else begin
            doRetag = 1'b1;
            if (i_needBG) begin
              stateNext   = LOAD;
              loadAdrNext = i_wrAdr;
            end else begin
              stateNext = IDLE;
            end
          end
        end
      end
      LOAD: begin
        if (i_loadAck) begin
          doMerge   = 1'b1;
          stateNext = IDLE;
        end
      end
      FLUSH: begin
        if (|victimLine.mask) begin
          doCapture = 1'b1;
          stateNext = EVICT;
        end else begin
          doInval = 1'b1;
          if (victimReg == LAST_IDX) begin
            stateNext     = IDLE;
            flushDoneNext = 1'b1;
            flushingNext  = 1'b0;
          end else begin
            victimNext = victimReg + 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      stateReg     <= IDLE;
      rrPtrReg     <= '0;
      victimReg    <= '0;
      flushingReg  <= 1'b0;
      flushDoneReg <= 1'b0;
      loadAdrReg   <= '0;
      saveAdrReg   <= '0;
      saveDataReg  <= '0;
      saveMaskReg  <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        lineReg[i] <= '0;
        dataReg[i] <= '0;
      end
    end else begin
      stateReg     <= stateNext;
      victimReg    <= victimNext;
      flushingReg  <= flushingNext;
      flushDoneReg <= flushDoneNext;
      loadAdrReg   <= loadAdrNext;
      if (rrAdvance) rrPtrReg <= rrPtrReg + 1'b1;
      if (doWrite) begin
        lineReg[hitIdx].mask <= hitLine.mask | wrEnExp;
        dataReg[hitIdx]      <= wrMerged;
      end
      if (doRetag) begin
        lineReg[victimNext] <= '{tag: i_wrAdr, valid: 1'b1, loaded: 1'b0, mask: '0};
      end
      if (doCapture) begin
        saveAdrReg  <= lineReg[victimNext].tag;
        saveDataReg <= dataReg[victimNext];
        saveMaskReg <= lineReg[victimNext].mask;
      end
      if (doInval) lineReg[victimReg] <= '0;
      if (doMerge) begin
        dataReg[victimReg]        <= ldMerged;
        lineReg[victimReg].loaded <= 1'b1;
      end
    end
  end

  assign o_loadReq   = (stateReg == LOAD);
  assign o_loadAdr   = loadAdrReg;
  assign o_saveReq   = (stateReg == EVICT);
  assign o_saveAdr   = saveAdrReg;
  assign o_saveData  = saveDataReg;
  assign o_saveMask  = saveMaskReg;
  assign o_flushDone = flushDoneReg;

endmodule
